// File: rtl/led_pattern_seq_if.sv
// Handshake/bus bundle between the LED pattern sequencer and its environment.
// The master side drives tick/button/speed; the slave side (the sequencer) drives the LEDs.
interface led_pattern_seq_if;
  logic       tick;
  logic       btn;
  logic [1:0] speed;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  modport master (
    output tick,
    output btn,
    output speed,
    input  led,
    input  mode,
    input  step
  );

  modport slave (
    input  tick,
    input  btn,
    input  speed,
    output led,
    output mode,
    output step
  );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: debounced button cycles BLINK/CHASE/BOUNCE/BREATHE,
// and the divider tick, divided down by 2^speed, advances the active pattern.
module led_pattern_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PWM_BITS        = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int                  DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]     DB_ONE   = DB_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  // Button path
  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  // Step generation
  logic [2:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] limit;
  logic       fire;

  // Pattern state and registered outputs
  mode_e               mode_q, mode_d;
  logic                step_q, step_d;
  logic [7:0]          led_q, led_d;
  logic [7:0]          pat_q, pat_d;
  logic                dir_right_q, dir_right_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_down_q, duty_down_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path can infer a latch.
    db_d        = db_q;
    db_cnt_d    = '0;
    press       = 1'b0;
    limit       = 3'd0;
    fire        = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_ONE;
    mode_d      = mode_q;
    step_d      = 1'b0;
    pat_d       = pat_q;
    dir_right_d = dir_right_q;
    duty_d      = duty_q;
    duty_down_d = duty_down_q;
    led_d       = led_q;

    // Accept a new button level only after it has persisted DEBOUNCE_CYCLES edges.
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d  = sync2_q;
        press = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end

    unique case (bus.speed)
      2'd0: limit = 3'd0;
      2'd1: limit = 3'd1;
      2'd2: limit = 3'd3;
      2'd3: limit = 3'd7;
    endcase

    // The >= compare lets a speed decrease take effect on the very next tick.
    if (bus.tick) begin
      if (tick_cnt_q >= limit) begin
        fire       = 1'b1;
        tick_cnt_d = 3'd0;
      end else begin
        tick_cnt_d = tick_cnt_q + 3'd1;
      end
    end

    if (press) begin
      // Mode change wins over a coincident step.
      mode_d      = mode_e'(2'(mode_q) + 2'd1);
      tick_cnt_d  = 3'd0;
      pat_d       = (mode_d == MODE_CHASE || mode_d == MODE_BOUNCE) ? 8'h01 : 8'h00;
      dir_right_d = 1'b0;
      duty_d      = '0;
      duty_down_d = 1'b0;
    end else if (fire) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_BLINK: pat_d = ~pat_q;
        MODE_CHASE: pat_d = {pat_q[6:0], pat_q[7]};
        MODE_BOUNCE: begin
          if (!dir_right_q) begin
            pat_d = pat_q << 1;
            if (pat_d == 8'h80) dir_right_d = 1'b1;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_d == 8'h01) dir_right_d = 1'b0;
          end
        end
        MODE_BREATHE: begin
          if (!duty_down_q) begin
            duty_d = duty_q + PWM_ONE;
            if (duty_d == DUTY_MAX) duty_down_d = 1'b1;
          end else begin
            duty_d = duty_q - PWM_ONE;
            if (duty_d == '0) duty_down_d = 1'b0;
          end
        end
      endcase
    end

    if (mode_d == MODE_BREATHE) begin
      led_d = press ? 8'h00 : {8{pwm_cnt_q < duty_q}};
    end else begin
      led_d = pat_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      tick_cnt_q  <= 3'd0;
      pwm_cnt_q   <= '0;
      mode_q      <= MODE_BLINK;
      step_q      <= 1'b0;
      led_q       <= 8'h00;
      pat_q       <= 8'h00;
      dir_right_q <= 1'b0;
      duty_q      <= '0;
      duty_down_q <= 1'b0;
    end else begin
      sync1_q     <= bus.btn;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      led_q       <= led_d;
      pat_q       <= pat_d;
      dir_right_q <= dir_right_d;
      duty_q      <= duty_d;
      duty_down_q <= duty_down_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;
  assign bus.step = step_q;

endmodule
